lr_train_ctrl: RTL and testbench

//  Sequencer for the LR gradient-descent engine and its data-point RAM.
//  On start: primes the engine with the initial weight row, then streams data-point rows for the

---
 rtl/lr_train_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_lr_train_ctrl.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lr_train_ctrl.sv
// lr_train_ctrl: sequencer for the LR gradient-descent engine and its data-point RAM.
// Primes the engine with the weight row (RAM[0]), streams the row addressed by the engine's
// current index, waits for eng_fin, writes the final weights to RES_ADDR and pulses done.
// Ports:
//   CLK, RST          clock (rising edge), asynchronous active-high reset
//   start, abort      run request (IDLE only) / return to IDLE without writeback
//   busy, done, err   status: not IDLE, 1-cycle completion pulse, sticky timeout flag
//   epoch_cnt         epochs observed this run (DPS -> 1 index wraps, saturating)
//   mem_addr/we/wdata RAM address, write strobe and final weight row
//   mem_rdata         RAM read data, one cycle after mem_addr
//   eng_rst           1-cycle engine clear on an accepted start
//   eng_enable        engine advance enable (high exactly while running)
//   eng_idx, eng_fin  engine data-point index / training finished
//   eng_wt            engine weight row, valid while eng_fin=1
//   eng_row           row presented to the engine (registered copy of mem_rdata)
//   eng_row_oe        shared-bus drive enable, combinational so it drops with eng_fin
module lr_train_ctrl #(
   parameter int unsigned MAX_FEATURES = 7,
   parameter int unsigned DPS          = 6,
   parameter int unsigned DP_BITS      = 4,
   parameter int unsigned RES_ADDR     = DPS + 1,
   parameter int unsigned PRIME_CYC    = 3,
   parameter int unsigned WDOG_W       = 24,
   parameter int unsigned TIMEOUT      = 100000
) (
   input  logic                           CLK,
   input  logic                           RST,
   input  logic                           start,
   input  logic                           abort,
   output logic                           busy,
   output logic                           done,
   output logic                           err,
   output logic [7:0]                     epoch_cnt,
   output logic [DP_BITS-1:0]             mem_addr,
   output logic                           mem_we,
   output logic [(MAX_FEATURES+1)*16-1:0] mem_wdata,
   input  logic [(MAX_FEATURES+1)*16-1:0] mem_rdata,
   output logic                           eng_rst,
   output logic                           eng_enable,
   input  logic [DP_BITS-1:0]             eng_idx,
   input  logic                           eng_fin,
   input  logic [(MAX_FEATURES+1)*16-1:0] eng_wt,
   output logic [(MAX_FEATURES+1)*16-1:0] eng_row,
   output logic                           eng_row_oe
);

   localparam int unsigned ROW_W = (MAX_FEATURES + 1) * 16;
   localparam int unsigned PC_W  = (PRIME_CYC > 1) ? $clog2(PRIME_CYC) : 1;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_PRIME = 3'd1,
      S_RUN   = 3'd2,
      S_WB    = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t               r_state;
   state_t               w_next;

   logic [PC_W-1:0]      r_prime_cnt;
   logic [WDOG_W-1:0]    r_wdog;
   logic [DP_BITS-1:0]   r_idx_prev;

   logic                 r_busy;
   logic                 r_done;
   logic                 r_err;
   logic [7:0]           r_epoch;
   logic [DP_BITS-1:0]   r_mem_addr;
   logic                 r_mem_we;
   logic [ROW_W-1:0]     r_mem_wdata;
   logic                 r_eng_rst;
   logic                 r_eng_enable;
   logic [ROW_W-1:0]     r_eng_row;

   logic                 w_busy_nxt;
   logic                 w_done_nxt;
   logic                 w_err_nxt;
   logic [7:0]           w_epoch_nxt;
   logic [DP_BITS-1:0]   w_mem_addr_nxt;
   logic                 w_mem_we_nxt;
   logic [ROW_W-1:0]     w_mem_wdata_nxt;
   logic                 w_eng_rst_nxt;
   logic                 w_eng_enable_nxt;
   logic [ROW_W-1:0]     w_eng_row_nxt;

   logic                 w_start_ok;
   logic                 w_prime_last;
   logic                 w_timeout;
   logic                 w_wrap;

   assign w_start_ok   = (r_state == S_IDLE) && start && !abort;
   assign w_prime_last = (r_prime_cnt == PC_W'(PRIME_CYC - 1));
   // r_wdog holds (RUN cycles elapsed - 1), so this fires in RUN cycle TIMEOUT
   assign w_timeout    = (r_state == S_RUN) && !eng_fin && (r_wdog == WDOG_W'(TIMEOUT - 1));
   assign w_wrap       = (r_state == S_RUN) && (r_idx_prev == DP_BITS'(DPS)) &&
                         (eng_idx == DP_BITS'(1));

   // State register
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   // Next-state logic; abort overrides everything, including start in IDLE
   always_comb begin
      w_next = r_state;
      if (abort) begin
         w_next = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE:  if (start) w_next = S_PRIME;
            S_PRIME: if (w_prime_last) w_next = S_RUN;
            S_RUN: begin
               if (eng_fin)        w_next = S_WB;
               else if (w_timeout) w_next = S_IDLE;
            end
            S_WB:    w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
         endcase
      end
   end

   // Output logic: next values of the registered outputs, decoded from the next state
   always_comb begin
      w_busy_nxt       = (w_next != S_IDLE);
      w_done_nxt       = (w_next == S_DONE);
      w_mem_we_nxt     = (w_next == S_WB);
      w_eng_enable_nxt = (w_next == S_RUN);
      w_eng_rst_nxt    = w_start_ok;
      w_err_nxt        = r_err;
      w_epoch_nxt      = r_epoch;
      w_mem_addr_nxt   = '0;
      w_mem_wdata_nxt  = r_mem_wdata;
      w_eng_row_nxt    = r_eng_row;

      if (w_start_ok)                        w_err_nxt = 1'b0;
      else if (w_timeout && !abort)          w_err_nxt = 1'b1;

      if (w_start_ok)                        w_epoch_nxt = '0;
      else if (w_wrap && r_epoch != 8'hFF)   w_epoch_nxt = r_epoch + 8'd1;

      case (w_next)
         S_RUN:   w_mem_addr_nxt = eng_idx;
         S_WB:    w_mem_addr_nxt = DP_BITS'(RES_ADDR);
         default: w_mem_addr_nxt = '0;
      endcase

      if (w_next == S_IDLE)                      w_mem_wdata_nxt = '0;
      else if (r_state == S_RUN && w_next == S_WB) w_mem_wdata_nxt = eng_wt;

      // RAM[0] is already on mem_rdata in IDLE, so the weight row lands with the start edge
      if (w_next == S_PRIME || w_next == S_RUN) w_eng_row_nxt = mem_rdata;
      else if (w_next == S_IDLE)                w_eng_row_nxt = '0;
   end

   // Output registers
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_err        <= 1'b0;
         r_epoch      <= '0;
         r_mem_addr   <= '0;
         r_mem_we     <= 1'b0;
         r_mem_wdata  <= '0;
         r_eng_rst    <= 1'b0;
         r_eng_enable <= 1'b0;
         r_eng_row    <= '0;
      end else begin
         r_busy       <= w_busy_nxt;
         r_done       <= w_done_nxt;
         r_err        <= w_err_nxt;
         r_epoch      <= w_epoch_nxt;
         r_mem_addr   <= w_mem_addr_nxt;
         r_mem_we     <= w_mem_we_nxt;
         r_mem_wdata  <= w_mem_wdata_nxt;
         r_eng_rst    <= w_eng_rst_nxt;
         r_eng_enable <= w_eng_enable_nxt;
         r_eng_row    <= w_eng_row_nxt;
      end
   end

   // Prime-hold counter, RUN watchdog and previous engine index
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_prime_cnt <= '0;
         r_wdog      <= '0;
         r_idx_prev  <= '0;
      end else begin
         r_prime_cnt <= (r_state == S_PRIME) ? r_prime_cnt + PC_W'(1) : '0;
         r_wdog      <= (r_state == S_RUN) ? r_wdog + WDOG_W'(1) : '0;
         r_idx_prev  <= eng_idx;
      end
   end

   assign busy       = r_busy;
   assign done       = r_done;
   assign err        = r_err;
   assign epoch_cnt  = r_epoch;
   assign mem_addr   = r_mem_addr;
   assign mem_we     = r_mem_we;
   assign mem_wdata  = r_mem_wdata;
   assign eng_rst    = r_eng_rst;
   assign eng_enable = r_eng_enable;
   assign eng_row    = r_eng_row;
   assign eng_row_oe = ((r_state == S_PRIME) || (r_state == S_RUN)) && !eng_fin;

endmodule

// File: tb/tb_lr_train_ctrl.sv
// Bench for lr_train_ctrl: two instances share stimulus; dut has a long watchdog for the
// nominal runs, dut_to uses TIMEOUT=50 for the watchdog scenarios. Each has its own RAM model.
module tb_lr_train_ctrl;

   localparam int unsigned ROW_W = 128;

   logic              CLK = 1'b0;
   logic              RST;
   logic              start, abort, eng_fin;
   logic [3:0]        eng_idx;
   logic [ROW_W-1:0]  eng_wt;

   logic              busy, done, err, mem_we, eng_rst, eng_enable, eng_row_oe;
   logic [7:0]        epoch_cnt;
   logic [3:0]        mem_addr;
   logic [ROW_W-1:0]  mem_wdata, mem_rdata, eng_row;

   logic              t_busy, t_done, t_err, t_mem_we, t_eng_rst, t_eng_enable, t_eng_row_oe;
   logic [7:0]        t_epoch_cnt;
   logic [3:0]        t_mem_addr;
   logic [ROW_W-1:0]  t_mem_wdata, t_mem_rdata, t_eng_row;

   logic [ROW_W-1:0]  ram [0:15];
   int                we_cnt = 0, done_cnt = 0, t_we_cnt = 0, t_done_cnt = 0;
   int                errors = 0, checks = 0;

   always #5 CLK = ~CLK;

   lr_train_ctrl #(.TIMEOUT(1000)) dut (
      .CLK(CLK), .RST(RST), .start(start), .abort(abort),
      .busy(busy), .done(done), .err(err), .epoch_cnt(epoch_cnt),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .eng_rst(eng_rst), .eng_enable(eng_enable), .eng_idx(eng_idx), .eng_fin(eng_fin),
      .eng_wt(eng_wt), .eng_row(eng_row), .eng_row_oe(eng_row_oe)
   );

   lr_train_ctrl #(.TIMEOUT(50)) dut_to (
      .CLK(CLK), .RST(RST), .start(start), .abort(abort),
      .busy(t_busy), .done(t_done), .err(t_err), .epoch_cnt(t_epoch_cnt),
      .mem_addr(t_mem_addr), .mem_we(t_mem_we), .mem_wdata(t_mem_wdata), .mem_rdata(t_mem_rdata),
      .eng_rst(t_eng_rst), .eng_enable(t_eng_enable), .eng_idx(eng_idx), .eng_fin(eng_fin),
      .eng_wt(eng_wt), .eng_row(t_eng_row), .eng_row_oe(t_eng_row_oe)
   );

   // Synchronous-read RAM models and write/done monitors
   always @(posedge CLK) begin
      mem_rdata   <= ram[mem_addr];
      t_mem_rdata <= ram[t_mem_addr];
      if (mem_we)   we_cnt++;
      if (done)     done_cnt++;
      if (t_mem_we) t_we_cnt++;
      if (t_done)   t_done_cnt++;
   end

   function automatic logic [ROW_W-1:0] row_of(input int i);
      logic [15:0] lane;
      lane = 16'h1100 + 16'(i);
      return {8{lane}};
   endfunction

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      RST = 1'b1; start = 1'b0; abort = 1'b0; eng_fin = 1'b0; eng_idx = '0; eng_wt = '0;
      tick(); tick();
      RST = 1'b0;
      tick(); tick();
   endtask

   task automatic test_reset();
      int guard;
      checks++;
      if ({busy, done, err, epoch_cnt, mem_addr, mem_we, eng_rst, eng_enable, eng_row_oe} !== '0) begin
         errors++; $display("FAIL reset_ctrl: got %0h required 0",
            {busy, done, err, epoch_cnt, mem_addr, mem_we, eng_rst, eng_enable, eng_row_oe});
      end
      checks++;
      if ({mem_wdata, eng_row} !== '0) begin
         errors++; $display("FAIL reset_rows: wdata=%0h row=%0h required 0", mem_wdata, eng_row);
      end
      // reset asserted mid-RUN
      eng_idx = 4'd1; start = 1'b1; tick(); start = 1'b0;
      guard = 0;
      while (eng_enable !== 1'b1 && guard < 10) begin tick(); guard++; end
      checks++;
      if (eng_enable !== 1'b1) begin errors++; $display("FAIL reset_reach_run: enable=%b required 1", eng_enable); end
      #3 RST = 1'b1;
      #1;
      checks++;
      if ({eng_enable, mem_we, busy} !== 3'b000) begin
         errors++; $display("FAIL reset_async: en/we/busy=%b required 000", {eng_enable, mem_we, busy});
      end
      #1 RST = 1'b0;
      tick();
      checks++;
      if ({busy, done, err, epoch_cnt, mem_addr, mem_we, eng_rst, eng_enable, eng_row_oe, mem_wdata, eng_row} !== '0) begin
         errors++; $display("FAIL reset_release: busy=%b en=%b oe=%b row=%0h required all 0",
            busy, eng_enable, eng_row_oe, eng_row);
      end
   endtask

   task automatic test_nominal();
      int prime_cnt, rst_cnt, row_bad, guard, we0, dn0;
      logic [ROW_W-1:0] wt;
      wt = {8{16'h0A5C}};
      do_reset();
      we0 = we_cnt; dn0 = done_cnt;
      eng_idx = 4'd1; start = 1'b1; tick(); start = 1'b0;
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL nom_busy: got %b required 1", busy); end
      prime_cnt = 0; rst_cnt = 0; row_bad = 0; guard = 0;
      while (eng_enable !== 1'b1 && guard < 10) begin
         if (eng_rst) rst_cnt++;
         if (eng_row !== ram[0] || eng_row_oe !== 1'b1) row_bad++;
         prime_cnt++; guard++;
         tick();
      end
      checks++;
      if (prime_cnt != 3) begin errors++; $display("FAIL nom_prime_len: got %0d required 3", prime_cnt); end
      checks++;
      if (rst_cnt != 1) begin errors++; $display("FAIL nom_eng_rst: got %0d pulses required 1", rst_cnt); end
      checks++;
      if (row_bad != 0) begin errors++; $display("FAIL nom_prime_row: got %0d bad cycles required 0", row_bad); end
      // 15 epochs of idx 1..6, each index held 4 cycles, ending on a wrap to 1
      for (int e = 0; e < 15; e++) begin
         for (int k = 2; k <= 6; k++) begin
            repeat (4) tick();
            eng_idx = 4'(k);
         end
         repeat (4) tick();
         eng_idx = 4'd1;
      end
      repeat (4) tick();
      eng_fin = 1'b1; eng_wt = wt;
      #1;
      checks++;
      if (eng_row_oe !== 1'b0) begin errors++; $display("FAIL nom_oe_fin: got %b required 0", eng_row_oe); end
      tick();
      eng_fin = 1'b0;
      checks++;
      if ({mem_we, mem_addr, eng_enable, done} !== {1'b1, 4'd7, 1'b0, 1'b0}) begin
         errors++; $display("FAIL nom_wb: we=%b addr=%0d en=%b done=%b required 1 7 0 0",
            mem_we, mem_addr, eng_enable, done);
      end
      checks++;
      if (mem_wdata !== wt) begin errors++; $display("FAIL nom_wdata: got %0h required %0h", mem_wdata, wt); end
      checks++;
      if (epoch_cnt !== 8'd15) begin errors++; $display("FAIL nom_epochs: got %0d required 15", epoch_cnt); end
      tick();
      checks++;
      if ({done, mem_we} !== 2'b10) begin errors++; $display("FAIL nom_done: done/we=%b required 10", {done, mem_we}); end
      tick();
      checks++;
      if ({done, busy} !== 2'b00 || we_cnt - we0 != 1 || done_cnt - dn0 != 1) begin
         errors++; $display("FAIL nom_end: done=%b busy=%b writes=%0d dones=%0d required 0 0 1 1",
            done, busy, we_cnt - we0, done_cnt - dn0);
      end
   endtask

   task automatic test_index_tracking();
      int guard;
      logic [ROW_W-1:0] prev;
      do_reset();
      eng_idx = 4'd6; start = 1'b1; tick(); start = 1'b0;
      guard = 0;
      while (eng_enable !== 1'b1 && guard < 10) begin tick(); guard++; end
      checks++;
      if (eng_enable !== 1'b1) begin errors++; $display("FAIL idx_reach_run: enable=%b required 1", eng_enable); end
      prev = ram[6];
      for (int k = 1; k <= 6; k++) begin
         eng_idx = 4'(k);
         tick();
         checks++;
         if (mem_addr !== 4'(k)) begin errors++; $display("FAIL idx_addr_%0d: got %0d required %0d", k, mem_addr, k); end
         tick();
         checks++;
         if (eng_row !== prev) begin errors++; $display("FAIL idx_early_%0d: got %0h required %0h", k, eng_row, prev); end
         tick();
         checks++;
         if (eng_row !== ram[k]) begin errors++; $display("FAIL idx_row_%0d: got %0h required %0h", k, eng_row, ram[k]); end
         tick();
         prev = ram[k];
      end
      checks++;
      if (epoch_cnt !== 8'd1) begin errors++; $display("FAIL idx_epoch: got %0d required 1", epoch_cnt); end
      abort = 1'b1; tick(); abort = 1'b0;
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL idx_abort: busy=%b required 0", busy); end
   endtask

   task automatic test_abort_fin();
      int guard, we0, dn0;
      do_reset();
      we0 = we_cnt; dn0 = done_cnt;
      eng_idx = 4'd2; start = 1'b1; tick(); start = 1'b0;
      guard = 0;
      while (eng_enable !== 1'b1 && guard < 10) begin tick(); guard++; end
      tick();
      abort = 1'b1; eng_fin = 1'b1; eng_wt = {8{16'hBEEF}};
      #1;
      checks++;
      if (eng_row_oe !== 1'b0) begin errors++; $display("FAIL abf_oe_same: got %b required 0", eng_row_oe); end
      tick();
      checks++;
      if ({busy, mem_we, eng_enable, eng_row_oe} !== 4'b0000 || mem_wdata !== '0) begin
         errors++; $display("FAIL abf_idle: busy/we/en/oe=%b wdata=%0h required 0000 0",
            {busy, mem_we, eng_enable, eng_row_oe}, mem_wdata);
      end
      abort = 1'b0; eng_fin = 1'b0;
      tick(); tick();
      checks++;
      if (we_cnt - we0 != 0 || done_cnt - dn0 != 0 || eng_row_oe !== 1'b0) begin
         errors++; $display("FAIL abf_nowrite: writes=%0d dones=%0d oe=%b required 0 0 0",
            we_cnt - we0, done_cnt - dn0, eng_row_oe);
      end
      start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
      checks++;
      if ({busy, eng_rst} !== 2'b00) begin errors++; $display("FAIL start_abort_idle: busy/rst=%b required 00", {busy, eng_rst}); end
   endtask

   task automatic test_timeout();
      int guard, run_cnt, we0, dn0;
      do_reset();
      we0 = t_we_cnt; dn0 = t_done_cnt;
      eng_idx = 4'd6; start = 1'b1; tick(); start = 1'b0;
      guard = 0;
      while (t_eng_enable !== 1'b1 && guard < 10) begin tick(); guard++; end
      checks++;
      if (t_err !== 1'b0) begin errors++; $display("FAIL to_err_early: got %b required 0", t_err); end
      eng_idx = 4'd1;
      run_cnt = 0; guard = 0;
      while (t_eng_enable === 1'b1 && guard < 200) begin run_cnt++; guard++; tick(); end
      checks++;
      if (run_cnt != 50) begin errors++; $display("FAIL to_run_len: got %0d required 50", run_cnt); end
      checks++;
      if ({t_err, t_busy, t_epoch_cnt} !== {1'b1, 1'b0, 8'd1}) begin
         errors++; $display("FAIL to_abort: err=%b busy=%b epoch=%0d required 1 0 1", t_err, t_busy, t_epoch_cnt);
      end
      tick(); tick();
      checks++;
      if (t_we_cnt - we0 != 0 || t_done_cnt - dn0 != 0 || t_err !== 1'b1) begin
         errors++; $display("FAIL to_nowrite: writes=%0d dones=%0d err=%b required 0 0 1",
            t_we_cnt - we0, t_done_cnt - dn0, t_err);
      end
   endtask

   task automatic test_restart_after_timeout();
      int guard;
      logic [ROW_W-1:0] wt;
      wt = {8{16'h0C0D}};
      start = 1'b1; tick(); start = 1'b0;
      checks++;
      if ({t_err, t_epoch_cnt, t_eng_rst, t_busy} !== {1'b0, 8'd0, 1'b1, 1'b1}) begin
         errors++; $display("FAIL rs_clear: err=%b epoch=%0d rst=%b busy=%b required 0 0 1 1",
            t_err, t_epoch_cnt, t_eng_rst, t_busy);
      end
      guard = 0;
      while (t_eng_enable !== 1'b1 && guard < 10) begin tick(); guard++; end
      tick();
      start = 1'b1; tick(); start = 1'b0;
      checks++;
      if ({t_eng_rst, t_eng_enable, t_busy} !== 3'b011) begin
         errors++; $display("FAIL rs_start_ignored: rst/en/busy=%b required 011", {t_eng_rst, t_eng_enable, t_busy});
      end
      eng_fin = 1'b1; eng_wt = wt;
      tick();
      eng_fin = 1'b0;
      checks++;
      if ({t_mem_we, t_mem_addr} !== {1'b1, 4'd7} || t_mem_wdata !== wt) begin
         errors++; $display("FAIL rs_wb: we=%b addr=%0d wdata=%0h required 1 7 %0h", t_mem_we, t_mem_addr, t_mem_wdata, wt);
      end
      tick();
      checks++;
      if (t_done !== 1'b1) begin errors++; $display("FAIL rs_done: got %b required 1", t_done); end
      tick();
      checks++;
      if (t_busy !== 1'b0) begin errors++; $display("FAIL rs_idle: busy=%b required 0", t_busy); end
   endtask

   initial begin
      for (int i = 0; i < 16; i++) ram[i] = row_of(i);
      ram[0] = {8{16'h0040}};
      do_reset();
      test_reset();
      test_nominal();
      test_index_tracking();
      test_abort_fin();
      test_timeout();
      test_restart_after_timeout();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
